// File: rtl/etrange_cache_pkg.sv
// Shared types and constants for the etrange cache datapath.
// Used by cache_reader and its output FIFO.
package etrange_cache_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 4;
    localparam int COORD_W      = 11;

    function automatic logic in_range(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] len
    );
        logic [COORD_W-1:0] hi;
        hi = lo + len;
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/cache_reader_fifo.sv
// Two-entry result FIFO for cache_reader, head visible while not popped.
// Flush drops every entry in one cycle and wins over push/pop.
module cache_reader_fifo
    import etrange_cache_pkg::*;
#(
    parameter int DW = PIX_W + 1
) (
    input  logic          p_clk,
    input  logic          preset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt_q;
    logic          do_pop;

    assign do_pop    = pop && (cnt_q != 2'd0);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt_q;

    // Storage, pointers and occupancy
    always_ff @(posedge p_clk or negedge preset_n) begin
        if (!preset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/cache_reader.sv
// Pixel reader over a filled tile cache: window test, RAM read, ordered FIFO out.
// Optional miss counter port enabled by CACHE_READER_STATS_EN.
module cache_reader
    import etrange_cache_pkg::*;
#(
    parameter int         ADDR_SIZE_W = 5,
    parameter int         ADDR_SIZE_H = 5,
    parameter int         DATA_SIZE   = 32,
    parameter logic [7:0] FILL_PIX    = 8'h00
) (
    input  logic                           p_clk,
    input  logic                           preset_n,
    input  logic                           cache_rdy,
    input  logic                           cache_inval,
    input  logic [9:0]                     decalage_w,
    input  logic [9:0]                     decalage_h,
    input  logic [9:0]                     cache_w,
    input  logic [9:0]                     cache_h,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_SIZE_W-1:0]         req_x,
    input  logic [ADDR_SIZE_H-1:0]         req_y,
    output logic                           ram_re,
    output logic [ADDR_SIZE_W+ADDR_SIZE_H-1:0] ram_addr,
    input  logic [DATA_SIZE-1:0]           ram_data,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [7:0]                     pix_out,
    output logic                           pix_in_win
`ifdef CACHE_READER_STATS_EN
   ,output logic [15:0]                    miss_cnt
`endif
);

    localparam int AW     = ADDR_SIZE_W + ADDR_SIZE_H;
    localparam int LANE_W = $clog2(PIX_PER_WORD);

    state_t                 state;
    state_t                 state_nxt;
    logic [9:0]             dw_q, dh_q, cw_q, ch_q;
    logic                   go, kill, accept, in_win, pop;
    logic [ADDR_SIZE_W-1:0] rel_x;
    logic [ADDR_SIZE_H-1:0] rel_y;
    logic [AW-1:0]          addr_calc;
    logic [2:0]             occ;
    logic                   s1_vld, s1_win;
    logic [LANE_W-1:0]      s1_lane;
    logic [PIX_W-1:0]       lane_pix;
    logic [PIX_W:0]         push_data, head;
    logic                   fifo_vld;
    logic [1:0]             fifo_cnt;

    assign go   = (state == IDLE) && cache_rdy && !cache_inval;
    assign kill = (state == SERVE) && cache_inval;

    // State register
    always_ff @(posedge p_clk or negedge preset_n) begin
        if (!preset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state: invalidate always wins, ready ignored while serving
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (go)          state_nxt = SERVE;
            SERVE: if (cache_inval) state_nxt = IDLE;
        endcase
    end

    // Window geometry captured at the start of a serve period
    always_ff @(posedge p_clk or negedge preset_n) begin
        if (!preset_n) begin
            dw_q <= '0;
            dh_q <= '0;
            cw_q <= '0;
            ch_q <= '0;
        end else if (go) begin
            dw_q <= decalage_w;
            dh_q <= decalage_h;
            cw_q <= cache_w;
            ch_q <= cache_h;
        end
    end

    // Window classification and word address of the request
    always_comb begin
        in_win = in_range(COORD_W'(req_x), {1'b0, dw_q}, {1'b0, cw_q})
              && in_range(COORD_W'(req_y), {1'b0, dh_q}, {1'b0, ch_q});
        rel_x  = req_x - dw_q[ADDR_SIZE_W-1:0];
        rel_y  = req_y - dh_q[ADDR_SIZE_H-1:0];
        addr_calc = (AW'(rel_y) << (ADDR_SIZE_W - LANE_W))
                  + AW'(rel_x >> LANE_W);
    end

    // Outputs: handshake, RAM request and FIFO head
    always_comb begin
        pop        = fifo_vld && pix_ready;
        occ        = {1'b0, fifo_cnt} + {2'b0, s1_vld} - {2'b0, pop};
        req_ready  = (state == SERVE) && (occ < 3'd2);
        accept     = req_valid && req_ready;
        ram_re     = accept && in_win;
        ram_addr   = ram_re ? addr_calc : '0;
        pix_valid  = fifo_vld;
        pix_out    = fifo_vld ? head[PIX_W-1:0] : '0;
        pix_in_win = fifo_vld && head[PIX_W];
    end

    // Read stage: one request waiting for its RAM word
    always_ff @(posedge p_clk or negedge preset_n) begin
        if (!preset_n) begin
            s1_vld  <= 1'b0;
            s1_win  <= 1'b0;
            s1_lane <= '0;
        end else begin
            s1_vld  <= accept && !kill;
            s1_win  <= in_win;
            s1_lane <= rel_x[LANE_W-1:0];
        end
    end

    // Byte lane pick or fill value for the result
    always_comb begin
        lane_pix  = ram_data[int'(s1_lane)*PIX_W +: PIX_W];
        push_data = s1_win ? {1'b1, lane_pix} : {1'b0, FILL_PIX};
    end

    cache_reader_fifo #(
        .DW(PIX_W + 1)
    ) u_fifo (
        .p_clk     (p_clk),
        .preset_n  (preset_n),
        .flush     (kill),
        .push      (s1_vld),
        .push_data (push_data),
        .pop       (pop),
        .out_valid (fifo_vld),
        .out_data  (head),
        .count     (fifo_cnt)
    );

`ifdef CACHE_READER_STATS_EN
    // Saturating count of accepted out-of-window requests
    always_ff @(posedge p_clk or negedge preset_n) begin
        if (!preset_n) begin
            miss_cnt <= '0;
        end else if (go) begin
            miss_cnt <= '0;
        end else if (accept && !in_win && (miss_cnt != 16'hFFFF)) begin
            miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_reader.sv
// Testbench for cache_reader: directed table, corner sequences, random stream.
// A cycle-level scoreboard predicts every handshake and pixel.
module tb_cache_reader;

    localparam int AW  = 5;
    localparam int AH  = 5;
    localparam int WPR = (1 << AW) / 4;

    logic        p_clk = 1'b0;
    logic        preset_n = 1'b0;
    logic        cache_rdy = 1'b0;
    logic        cache_inval = 1'b0;
    logic [9:0]  decalage_w = '0, decalage_h = '0;
    logic [9:0]  cache_w = '0, cache_h = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [AW-1:0] req_x = '0;
    logic [AH-1:0] req_y = '0;
    logic        ram_re;
    logic [AW+AH-1:0] ram_addr;
    logic [31:0] ram_data = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [7:0]  pix_out;
    logic        pix_in_win;
`ifdef CACHE_READER_STATS_EN
    logic [15:0] miss_cnt;
`endif

    cache_reader dut (
        .p_clk       (p_clk),
        .preset_n    (preset_n),
        .cache_rdy   (cache_rdy),
        .cache_inval (cache_inval),
        .decalage_w  (decalage_w),
        .decalage_h  (decalage_h),
        .cache_w     (cache_w),
        .cache_h     (cache_h),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .ram_re      (ram_re),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_out     (pix_out),
        .pix_in_win  (pix_in_win)
`ifdef CACHE_READER_STATS_EN
       ,.miss_cnt    (miss_cnt)
`endif
    );

    always #5 p_clk = ~p_clk;

    // Synchronous cache RAM model
    logic [31:0] mem [1024];
    always @(posedge p_clk) if (ram_re) ram_data <= mem[ram_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int       acc;
        bit       win;
        bit [7:0] pix;
    } exp_t;

    exp_t eq[$];
    exp_t e;
    int   cyc = 0, last_pop = -10, n_pops = 0;
    bit   serving = 0;
    int   m_dw, m_dh, m_cw, m_ch, m_miss = 0;
    int   due, u, v, xi, yi;
    bit   ev, ep;

    always @(negedge p_clk) begin
        if (!preset_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_pix_valid", 32'(pix_valid), 0);
            chk("rst_ram_re", 32'(ram_re), 0);
            chk("rst_pix_out", 32'(pix_out), 0);
`ifdef CACHE_READER_STATS_EN
            chk("rst_miss_cnt", 32'(miss_cnt), 0);
`endif
            eq.delete();
            serving = 0;
            m_miss  = 0;
        end else begin
            ev = 0;
            if (eq.size() > 0) begin
                due = eq[0].acc + 2;
                if (last_pop + 1 > due) due = last_pop + 1;
                ev = (cyc >= due);
            end
            ep = ev && pix_ready;
            chk("pix_valid", 32'(pix_valid), 32'(ev));
            if (pix_valid && ev) begin
                chk("pix_out", 32'(pix_out), 32'(eq[0].pix));
                chk("pix_in_win", 32'(pix_in_win), 32'(eq[0].win));
            end
            chk("req_ready", 32'(req_ready),
                32'(serving && (eq.size() - int'(ep)) < 2));
`ifdef CACHE_READER_STATS_EN
            chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
`endif
            if (req_valid && req_ready) begin
                xi = int'(req_x);
                yi = int'(req_y);
                e.acc = cyc;
                e.win = (xi >= m_dw) && (xi < m_dw + m_cw)
                     && (yi >= m_dh) && (yi < m_dh + m_ch);
                e.pix = 8'h00;
                if (e.win) begin
                    u = xi - m_dw;
                    v = yi - m_dh;
                    e.pix = 8'(mem[v*WPR + u/4] >> (8*(u%4)));
                    chk("ram_addr", 32'(ram_addr), 32'(v*WPR + u/4));
                end else if (m_miss < 65535) begin
                    m_miss++;
                end
                chk("ram_re", 32'(ram_re), 32'(e.win));
                eq.push_back(e);
            end else begin
                chk("ram_re_idle", 32'(ram_re), 0);
            end
            if (ep) begin
                void'(eq.pop_front());
                last_pop = cyc;
                n_pops++;
            end
            if (serving && cache_inval) begin
                eq.delete();
                serving = 0;
            end else if (!serving && cache_rdy && !cache_inval) begin
                serving = 1;
                m_dw = int'(decalage_w);
                m_dh = int'(decalage_h);
                m_cw = int'(cache_w);
                m_ch = int'(cache_h);
                m_miss = 0;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic start_serve(input int dw, input int dh,
                               input int cw, input int ch);
        cache_inval = 1'b1;
        tick();
        cache_inval = 1'b0;
        decalage_w  = 10'(dw);
        decalage_h  = 10'(dh);
        cache_w     = 10'(cw);
        cache_h     = 10'(ch);
        cache_rdy   = 1'b1;
        tick();
        cache_rdy   = 1'b0;
        decalage_w  = 10'($urandom);
        decalage_h  = 10'($urandom);
        cache_w     = 10'($urandom);
        cache_h     = 10'($urandom);
    endtask

    typedef struct {
        int          dw, dh, cw, ch, x, y, maddr;
        logic [31:0] mword;
        bit          exp_re;
        int          exp_addr;
        logic [7:0]  exp_pix;
    } vec_t;

    function automatic vec_t mk(int dw, int dh, int cw, int ch, int x, int y,
                                int maddr, logic [31:0] mword, bit re,
                                int addr, logic [7:0] pix);
        vec_t r;
        r.dw = dw; r.dh = dh; r.cw = cw; r.ch = ch;
        r.x = x; r.y = y; r.maddr = maddr; r.mword = mword;
        r.exp_re = re; r.exp_addr = addr; r.exp_pix = pix;
        return r;
    endfunction

    vec_t tv[11];
    int   acc, pops0, first_acc;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        tv[0]  = mk(0, 0, 32, 32, 5, 3, 25, 32'hDDCCBBAA, 1, 25, 8'hBB);
        tv[1]  = mk(4, 0, 28, 32, 2, 0, 1023, 32'h0, 0, 0, 8'h00);
        tv[2]  = mk(4, 2, 8, 8, 4, 2, 0, 32'h44332211, 1, 0, 8'h11);
        tv[3]  = mk(4, 2, 8, 8, 11, 9, 57, 32'h88776655, 1, 57, 8'h88);
        tv[4]  = mk(4, 2, 8, 8, 12, 9, 1023, 32'h0, 0, 0, 8'h00);
        tv[5]  = mk(4, 2, 8, 8, 11, 10, 1023, 32'h0, 0, 0, 8'h00);
        tv[6]  = mk(4, 2, 8, 8, 3, 5, 1023, 32'h0, 0, 0, 8'h00);
        tv[7]  = mk(0, 0, 0, 0, 0, 0, 1023, 32'h0, 0, 0, 8'h00);
        tv[8]  = mk(1000, 0, 1000, 32, 31, 0, 1023, 32'h0, 0, 0, 8'h00);
        tv[9]  = mk(0, 0, 1023, 1023, 31, 31, 255, 32'hF0E0D0C0, 1, 255, 8'hF0);
        tv[10] = mk(1, 1, 31, 31, 2, 1, 0, 32'h44332211, 1, 0, 8'h22);

        // reset state
        tick();
        @(negedge p_clk);
        chk("reset_ram_addr", 32'(ram_addr), 0);
        chk("reset_pix_in_win", 32'(pix_in_win), 0);
        tick();
        preset_n = 1'b1;
        tick();
        @(negedge p_clk);
        chk("idle_req_ready", 32'(req_ready), 0);
        tick();

        // directed table: one request per fresh window
        pix_ready = 1'b1;
        foreach (tv[i]) begin
            mem[tv[i].maddr] = tv[i].mword;
            start_serve(tv[i].dw, tv[i].dh, tv[i].cw, tv[i].ch);
            req_x = AW'(tv[i].x);
            req_y = AH'(tv[i].y);
            req_valid = 1'b1;
            @(negedge p_clk);
            chk("tv_req_ready", 32'(req_ready), 1);
            chk("tv_ram_re", 32'(ram_re), 32'(tv[i].exp_re));
            if (tv[i].exp_re) chk("tv_ram_addr", 32'(ram_addr), 32'(tv[i].exp_addr));
            tick();
            req_valid = 1'b0;
            @(negedge p_clk);
            chk("tv_pix_early", 32'(pix_valid), 0);
            tick();
            @(negedge p_clk);
            chk("tv_pix_valid", 32'(pix_valid), 1);
            chk("tv_pix_out", 32'(pix_out), 32'(tv[i].exp_pix));
            chk("tv_pix_in_win", 32'(pix_in_win), 32'(tv[i].exp_re));
`ifdef CACHE_READER_STATS_EN
            chk("tv_miss_cnt", 32'(miss_cnt), tv[i].exp_re ? 0 : 1);
`endif
            tick();
        end

        // 64 back-to-back requests
        start_serve(0, 0, 32, 32);
        pops0 = n_pops;
        first_acc = cyc;
        req_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            req_x = AW'(k % 32);
            req_y = AH'(k / 32 + 4);
            @(negedge p_clk);
            chk("b2b_ready", 32'(req_ready), 1);
            tick();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("b2b_count", 32'(n_pops - pops0), 64);
        chk("b2b_last", 32'(last_pop), 32'(first_acc + 65));

        // backpressure: ready low while results pile up
        start_serve(0, 0, 32, 32);
        pops0 = n_pops;
        pix_ready = 1'b0;
        req_valid = 1'b1;
        req_y = 5'd9;
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            req_x = AW'(k);
            @(negedge p_clk);
            if (req_valid && req_ready) acc++;
            tick();
        end
        chk("bp_accepts", 32'(acc), 2);
        pix_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            req_x = AW'(k + 7);
            if (k >= 10) req_valid = 1'b0;
            @(negedge p_clk);
            if (req_valid && req_ready) acc++;
            tick();
        end
        chk("bp_drain", 32'(n_pops - pops0), 32'(acc));

        // invalidate with two results pending, rdy in the same cycle
        start_serve(0, 0, 32, 32);
        pix_ready = 1'b0;
        req_valid = 1'b1;
        req_y = 5'd7;
        for (int k = 0; k < 2; k++) begin
            req_x = AW'(k);
            tick();
        end
        req_valid = 1'b0;
        tick();
        tick();
        cache_inval = 1'b1;
        cache_rdy = 1'b1;
        @(negedge p_clk);
        chk("inv_pending", 32'(pix_valid), 1);
        tick();
        cache_inval = 1'b0;
        cache_rdy = 1'b0;
        @(negedge p_clk);
        chk("inv_pix_valid", 32'(pix_valid), 0);
        chk("inv_req_ready", 32'(req_ready), 0);
        tick();
        @(negedge p_clk);
        chk("inv_stay_idle", 32'(req_ready), 0);
        tick();
        pix_ready = 1'b1;

        // reset mid-stream
        start_serve(0, 0, 32, 32);
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_x = AW'(k);
            tick();
        end
        preset_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_ram_re", 32'(ram_re), 0);
        chk("mid_rst_ram_addr", 32'(ram_addr), 0);
        chk("mid_rst_pix_valid", 32'(pix_valid), 0);
        chk("mid_rst_pix_out", 32'(pix_out), 0);
        chk("mid_rst_pix_in_win", 32'(pix_in_win), 0);
        tick();
        tick();
        preset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge p_clk);
            chk("post_rst_req_ready", 32'(req_ready), 0);
            chk("post_rst_pix_valid", 32'(pix_valid), 0);
            tick();
        end
        req_valid = 1'b0;

        // random stream against the scoreboard
        for (int r = 0; r < 4; r++) begin
            start_serve($urandom_range(0, 8), $urandom_range(0, 8),
                        $urandom_range(0, 32), $urandom_range(0, 32));
            for (int k = 0; k < 250; k++) begin
                req_valid = ($urandom_range(0, 3) != 0);
                pix_ready = ($urandom_range(0, 2) != 0);
                req_x = AW'($urandom);
                req_y = AH'($urandom);
                tick();
            end
            req_valid = 1'b0;
            pix_ready = 1'b1;
            for (int k = 0; k < 4; k++) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
